mod_counter_div: RTL and testbench

MOD_COUNTER_DIV -- requirements
Module: mod_counter_div

---
 rtl/mod_counter_div_if.sv | 25 ++
 rtl/mod_counter_div.sv | 60 ++++++
 tb/tb_mod_counter_div.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mod_counter_div_if.sv
// Control and status bundle for one modulo counter/divider stage.
// master drives the controls; slave is the counter itself.
interface mod_counter_div_if #(
    parameter int unsigned WIDTH = 4
);
    logic             ce;
    logic             cin;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             cout;
    logic             div_out;

    modport master (
        output ce, cin, up_dn, load, load_val,
        input  count, tc, cout, div_out
    );

    modport slave (
        input  ce, cin, up_dn, load, load_val,
        output count, tc, cout, div_out
    );
endinterface

// File: rtl/mod_counter_div.sv
// Cascadable up/down modulo-MODULUS counter with load and a 50% duty divided clock output.
// Chain stages by feeding cout into the next stage's cin with a shared ce.
module mod_counter_div #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input logic               clk,
    input logic               reset,
    mod_counter_div_if.slave  bus
);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("mod_counter_div: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             div_q, div_d;
    logic             adv;
    logic             tc;
    logic             wrap;

    assign adv  = bus.ce & bus.cin;
    assign tc   = bus.up_dn ? (count_q == MaxVal) : (count_q == '0);
    assign wrap = tc & adv;

    always_comb begin
        count_d = count_q;
        if (bus.load) begin
            // Out-of-range loads clamp so the count can never leave 0..MODULUS-1.
            count_d = (bus.load_val > MaxVal) ? MaxVal : bus.load_val;
        end else if (adv) begin
            if (bus.up_dn) begin
                count_d = tc ? '0 : count_q + 1'b1;
            end else begin
                count_d = tc ? MaxVal : count_q - 1'b1;
            end
        end
    end

    // A load overrides the advance, so it must not count as a wrap.
    assign div_d = div_q ^ (wrap & ~bus.load);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            div_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            div_q   <= div_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.tc      = tc;
    assign bus.cout    = wrap;
    assign bus.div_out = div_q;

endmodule

// File: tb/tb_mod_counter_div.sv
// Checks a two-stage decade cascade and a WIDTH=3/MODULUS=8 stage against an
// arithmetic model every cycle, plus hand-computed expectations.
module tb_mod_counter_div;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mod_counter_div_if #(.WIDTH(4)) if_lo ();
    mod_counter_div_if #(.WIDTH(4)) if_hi ();
    mod_counter_div_if #(.WIDTH(3)) if_w3 ();

    assign if_hi.ce       = if_lo.ce;
    assign if_hi.cin      = if_lo.cout;
    assign if_hi.up_dn    = if_lo.up_dn;
    assign if_hi.load     = 1'b0;
    assign if_hi.load_val = '0;

    assign if_w3.ce       = if_lo.ce;
    assign if_w3.cin      = 1'b1;
    assign if_w3.up_dn    = if_lo.up_dn;
    assign if_w3.load     = 1'b0;
    assign if_w3.load_val = '0;

    mod_counter_div #(.WIDTH(4), .MODULUS(10)) u_lo (.clk(clk), .reset(reset), .bus(if_lo));
    mod_counter_div #(.WIDTH(4), .MODULUS(10)) u_hi (.clk(clk), .reset(reset), .bus(if_hi));
    mod_counter_div #(.WIDTH(3), .MODULUS(8))  u_w3 (.clk(clk), .reset(reset), .bus(if_w3));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain modular arithmetic on integers.
    function automatic int nxt(int c, int m, bit up, bit ld, int lv, bit adv);
        if (ld) return (lv >= m) ? m - 1 : lv;
        if (!adv) return c;
        if (up) return (c + 1) % m;
        return (c + m - 1) % m;
    endfunction

    function automatic bit tcf(int c, int m, bit up);
        return up ? (c == m - 1) : (c == 0);
    endfunction

    int m_lo = 0, m_hi = 0, m_w3 = 0;
    bit d_lo = 0, d_hi = 0, d_w3 = 0;
    bit started = 0;

    function automatic bit lo_cout_m();
        return tcf(m_lo, 10, if_lo.up_dn) & if_lo.ce & if_lo.cin;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            started <= 1'b1;
            m_lo <= 0; m_hi <= 0; m_w3 <= 0;
            d_lo <= 1'b0; d_hi <= 1'b0; d_w3 <= 1'b0;
        end else begin
            m_lo <= nxt(m_lo, 10, if_lo.up_dn, if_lo.load, int'(if_lo.load_val),
                        if_lo.ce & if_lo.cin);
            d_lo <= d_lo ^ (lo_cout_m() & ~if_lo.load);
            m_hi <= nxt(m_hi, 10, if_lo.up_dn, 1'b0, 0, if_lo.ce & lo_cout_m());
            d_hi <= d_hi ^ (tcf(m_hi, 10, if_lo.up_dn) & if_lo.ce & lo_cout_m());
            m_w3 <= nxt(m_w3, 8, if_lo.up_dn, 1'b0, 0, if_lo.ce);
            d_w3 <= d_w3 ^ (tcf(m_w3, 8, if_lo.up_dn) & if_lo.ce);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("lo_count", 32'(if_lo.count), m_lo);
            check("lo_tc",    32'(if_lo.tc), 32'(tcf(m_lo, 10, if_lo.up_dn)));
            check("lo_cout",  32'(if_lo.cout), 32'(lo_cout_m()));
            check("lo_div",   32'(if_lo.div_out), 32'(d_lo));
            check("hi_count", 32'(if_hi.count), m_hi);
            check("hi_cout",  32'(if_hi.cout),
                  32'(tcf(m_hi, 10, if_lo.up_dn) & if_lo.ce & lo_cout_m()));
            check("hi_div",   32'(if_hi.div_out), 32'(d_hi));
            check("w3_count", 32'(if_w3.count), m_w3);
            check("w3_tc",    32'(if_w3.tc), 32'(tcf(m_w3, 8, if_lo.up_dn)));
            check("w3_div",   32'(if_w3.div_out), 32'(d_w3));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        if_lo.ce = 1'b1; if_lo.cin = 1'b1; if_lo.up_dn = 1'b1;
        if_lo.load = 1'b0; if_lo.load_val = '0;
        tick(1);
        check("rst_count", 32'(if_lo.count), 0);
        check("rst_div", 32'(if_lo.div_out), 0);
        check("rst_tc_up", 32'(if_lo.tc), 0);
        if_lo.up_dn = 1'b0;
        #1;
        check("rst_tc_down", 32'(if_lo.tc), 1);
        check("rst_w3_tc_down", 32'(if_w3.tc), 1);
        if_lo.up_dn = 1'b1;
        reset = 1'b0;

        // Up count, divided clock and two-stage cascade 00..99 then 00.
        for (int k = 1; k <= 100; k++) begin
            tick(1);
            check("up_count", 32'(if_lo.count), k % 10);
            check("up_div", 32'(if_lo.div_out), (k / 10) % 2);
            check("casc_hi", 32'(if_hi.count), (k / 10) % 10);
            check("w3_wrap", 32'(if_w3.count), k % 8);
            check("w3_div_lit", 32'(if_w3.div_out), (k / 8) % 2);
        end

        // Down mode from reset.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        if_lo.up_dn = 1'b0;
        #1;
        check("dn_tc0", 32'(if_lo.tc), 1);
        tick(1);
        check("dn_wrap", 32'(if_lo.count), 9);
        check("dn_div", 32'(if_lo.div_out), 1);
        tick(1);
        check("dn_8", 32'(if_lo.count), 8);

        // Loads, clamping, and a load coinciding with terminal count.
        if_lo.ce = 1'b0; if_lo.load = 1'b1; if_lo.load_val = 4'd7;
        tick(1);
        check("load7", 32'(if_lo.count), 7);
        if_lo.load_val = 4'd13;
        tick(1);
        check("load13_clamp", 32'(if_lo.count), 9);
        if_lo.up_dn = 1'b1; if_lo.ce = 1'b1; if_lo.load_val = 4'd3;
        #1;
        check("load_tc_cout", 32'(if_lo.cout), 1);
        tick(1);
        check("load_tc_count", 32'(if_lo.count), 3);
        check("load_no_toggle", 32'(if_lo.div_out), 1);

        // ce toggling and cin=0 window hold the count.
        if_lo.load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if_lo.ce = i[0];
            tick(1);
        end
        check("ce_toggle", 32'(if_lo.count), 7);
        if_lo.ce = 1'b1; if_lo.cin = 1'b0;
        tick(3);
        check("cin_hold", 32'(if_lo.count), 7);
        if_lo.cin = 1'b1; if_lo.ce = 1'b0; if_lo.load = 1'b1; if_lo.load_val = 4'd9;
        tick(1);
        if_lo.load = 1'b0;
        #1;
        check("hold_tc", 32'(if_lo.tc), 1);
        check("hold_cout_ce0", 32'(if_lo.cout), 0);
        if_lo.ce = 1'b1; if_lo.cin = 1'b0;
        #1;
        check("hold_cout_cin0", 32'(if_lo.cout), 0);
        if_lo.cin = 1'b1;
        #1;
        check("cout_adv", 32'(if_lo.cout), 1);
        tick(1);
        check("wrap_div0", 32'(if_lo.div_out), 0);
        tick(10);
        check("wrap_div1", 32'(if_lo.div_out), 1);

        // Reset beats a simultaneous load mid-count.
        if_lo.load = 1'b1; if_lo.load_val = 4'd6;
        tick(1);
        check("pre_rst6", 32'(if_lo.count), 6);
        reset = 1'b1; if_lo.load_val = 4'd2;
        tick(1);
        check("rst_over_load", 32'(if_lo.count), 0);
        check("rst_div_clr", 32'(if_lo.div_out), 0);
        reset = 1'b0; if_lo.load = 1'b0;
        tick(1);
        check("resume", 32'(if_lo.count), 1);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
